dependency_check_pipe: RTL and testbench

Parametrised successor to the decode-stage dependency checker in the 16-bit MIPS pipeline. Decodes each issued instruction and tracks FWD_DEPTH in-flight writers (EX, DM, WB, ...). Produces per-operand forwarding selects, registered decode/control outputs and memory controls. Adds two things the previous block lacked: load-use stall detection with bubble insertion, and an ins_valid qualifier.

---
 rtl/dependency_check_pipe_pkg.sv | 56 +++++
 rtl/dependency_check_pipe_if.sv | 31 +++
 rtl/dependency_check_pipe_fwd_match.sv | 41 ++++
 rtl/dependency_check_pipe.sv | 134 +++++++++++++
 tb/tb_dependency_check_pipe.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/dependency_check_pipe_pkg.sv
// Shared opcodes, instruction field positions, tracker entry layout and the
// opcode decoder used by the dependency checker.
package dcp_pkg;

  // Instruction field layout: op[31:26], rd[25:21], rs[20:16], rt[15:11], imm[15:0]
  localparam int OP_W    = 6;
  localparam int FIELD_W = 5;
  localparam int IMM_W   = 16;
  localparam int OP_LSB  = 26;
  localparam int RD_LSB  = 21;
  localparam int RS_LSB  = 16;
  localparam int RT_LSB  = 11;
  localparam int IMM_LSB = 0;

  localparam logic [OP_W-1:0] OP_LD = 6'h14;
  localparam logic [OP_W-1:0] OP_ST = 6'h15;
  // Immediate ALU class is every opcode whose top three bits are 001
  localparam logic [2:0] IMM_CLASS_HI = 3'b001;

  typedef enum logic [1:0] {
    CLS_R   = 2'd0,
    CLS_IMM = 2'd1,
    CLS_LD  = 2'd2,
    CLS_ST  = 2'd3
  } ins_class_e;

  // One in-flight writer slot (entry 0 = EX, 1 = DM, 2 = WB, ...)
  typedef struct packed {
    logic               valid;
    logic               writes;
    logic               is_load;
    logic [FIELD_W-1:0] dest;
  } trk_entry_t;

  typedef struct packed {
    ins_class_e cls;
    logic       b_used;
    logic       writes;
  } dec_t;

  // Classify an opcode and report whether it reads a B register source
  function automatic dec_t decode_op(input logic [OP_W-1:0] op);
    dec_t d;
    d.cls = CLS_R;
    if (op == OP_LD)
      d.cls = CLS_LD;
    else if (op == OP_ST)
      d.cls = CLS_ST;
    else if (op[5:3] == IMM_CLASS_HI)
      d.cls = CLS_IMM;
    d.b_used = (d.cls == CLS_R) || (d.cls == CLS_ST);
    d.writes = (d.cls != CLS_ST);
    return d;
  endfunction

endpackage

// File: rtl/dependency_check_pipe_if.sv
// Instruction issue / decode-output bundle between the issue stage and the
// dependency checker.
interface dependency_check_pipe_if #(
  parameter int REG_AW = 5,
  parameter int SEL_W  = 2
);
  logic              ins_valid;
  logic [31:0]       ins;
  logic              stall;
  logic [15:0]       imm;
  logic [5:0]        op_dec;
  logic [REG_AW-1:0] rw_dm;
  logic [SEL_W-1:0]  mux_sel_a;
  logic [SEL_W-1:0]  mux_sel_b;
  logic              imm_sel;
  logic              mem_en_ex;
  logic              mem_rw_ex;
  logic              mem_mux_sel_dm;

  modport master (
    output ins_valid, ins,
    input  stall, imm, op_dec, rw_dm, mux_sel_a, mux_sel_b,
           imm_sel, mem_en_ex, mem_rw_ex, mem_mux_sel_dm
  );

  modport slave (
    input  ins_valid, ins,
    output stall, imm, op_dec, rw_dm, mux_sel_a, mux_sel_b,
           imm_sel, mem_en_ex, mem_rw_ex, mem_mux_sel_dm
  );
endinterface

// File: rtl/dependency_check_pipe_fwd_match.sv
// Priority match of one source register against the in-flight writer
// tracker. Returns k+1 for the youngest matching entry k (0 = no match) and
// whether that winning entry is a load.
module dcp_fwd_match
  import dcp_pkg::*;
#(
  parameter int FWD_DEPTH = 3,
  parameter int SEL_W     = 2,
  parameter int ZERO_REG  = 1
) (
  input  logic [FIELD_W-1:0]           src,
  input  trk_entry_t [FWD_DEPTH-1:0]   trk,
  output logic [SEL_W-1:0]             sel,
  output logic                         sel_is_load
);

  localparam bit ZERO_EXCL = (ZERO_REG != 0);

  logic [FWD_DEPTH-1:0] hit;
  logic                 src_excluded;

  assign src_excluded = ZERO_EXCL && (src == '0);

  for (genvar gi = 0; gi < FWD_DEPTH; gi++) begin : g_hit
    assign hit[gi] = trk[gi].valid && trk[gi].writes &&
                     (trk[gi].dest == src) && !src_excluded;
  end

  // Scan oldest to youngest so the youngest hit overwrites and wins
  always_comb begin
    sel         = '0;
    sel_is_load = 1'b0;
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      if (hit[k]) begin
        sel         = SEL_W'(k + 1);
        sel_is_load = trk[k].is_load;
      end
    end
  end

endmodule

// File: rtl/dependency_check_pipe.sv
// Decode-stage dependency checker: decodes the issued instruction, tracks
// FWD_DEPTH in-flight writers, produces forwarding selects and memory
// controls, and stalls one cycle on a load-use hazard.
module dependency_check_pipe
  import dcp_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 3,
  parameter int SEL_W     = 2,
  parameter int ZERO_REG  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  dependency_check_pipe_if.slave bus
);

  logic [OP_W-1:0]    op;
  logic [FIELD_W-1:0] rd_f;
  logic [FIELD_W-1:0] rs_f;
  logic [FIELD_W-1:0] rt_f;
  logic [FIELD_W-1:0] src_b;
  dec_t               dec;
  logic               accept;
  logic               stall;
  trk_entry_t         new_entry;

  trk_entry_t [FWD_DEPTH-1:0] trk_reg;

  logic [SEL_W-1:0] sel_a;
  logic [SEL_W-1:0] sel_b;
  logic             load_a;
  logic             load_b;

  logic [OP_W-1:0]  op_dec_reg;
  logic [SEL_W-1:0] mux_sel_a_reg;
  logic [SEL_W-1:0] mux_sel_b_reg;
  logic             imm_sel_reg;
  logic             mem_en_ex_reg;
  logic             mem_rw_ex_reg;
  logic [IMM_W-1:0] imm_reg;

  assign op   = bus.ins[OP_LSB +: OP_W];
  assign rd_f = FIELD_W'(bus.ins[RD_LSB +: REG_AW]);
  assign rs_f = FIELD_W'(bus.ins[RS_LSB +: REG_AW]);
  assign rt_f = FIELD_W'(bus.ins[RT_LSB +: REG_AW]);
  assign dec  = decode_op(op);

  // A store's rt slot overlaps its offset, and a store writes nothing, so
  // the store-data register travels in the rd slot
  assign src_b = (dec.cls == CLS_ST) ? rd_f : rt_f;

  dcp_fwd_match #(
    .FWD_DEPTH (FWD_DEPTH),
    .SEL_W     (SEL_W),
    .ZERO_REG  (ZERO_REG)
  ) u_match_a (
    .src         (rs_f),
    .trk         (trk_reg),
    .sel         (sel_a),
    .sel_is_load (load_a)
  );

  dcp_fwd_match #(
    .FWD_DEPTH (FWD_DEPTH),
    .SEL_W     (SEL_W),
    .ZERO_REG  (ZERO_REG)
  ) u_match_b (
    .src         (src_b),
    .trk         (trk_reg),
    .sel         (sel_b),
    .sel_is_load (load_b)
  );

  // A winning select of 1 means the youngest (EX) entry matched; if that is
  // a load its data is not ready yet, so hold the instruction one cycle
  assign stall = reset && bus.ins_valid &&
                 ((sel_a == SEL_W'(1) && load_a) ||
                  (dec.b_used && sel_b == SEL_W'(1) && load_b));

  assign accept = bus.ins_valid && !stall;

  // Entry entering EX: the accepted instruction, or a bubble
  always_comb begin
    new_entry = '0;
    if (accept) begin
      new_entry.valid   = 1'b1;
      new_entry.writes  = dec.writes;
      new_entry.is_load = (dec.cls == CLS_LD);
      new_entry.dest    = rd_f;
    end
  end

  // Shift the writer tracker every cycle; the oldest entry falls off
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      trk_reg <= '0;
    else
      trk_reg <= {trk_reg[FWD_DEPTH-2:0], new_entry};
  end

  // Register decode results; a bubble or stall clears controls, imm holds on stall
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_dec_reg    <= '0;
      mux_sel_a_reg <= '0;
      mux_sel_b_reg <= '0;
      imm_sel_reg   <= 1'b0;
      mem_en_ex_reg <= 1'b0;
      mem_rw_ex_reg <= 1'b0;
      imm_reg       <= '0;
    end else begin
      op_dec_reg    <= accept ? op : '0;
      mux_sel_a_reg <= accept ? sel_a : '0;
      mux_sel_b_reg <= (accept && dec.b_used) ? sel_b : '0;
      imm_sel_reg   <= accept && (dec.cls != CLS_R);
      mem_en_ex_reg <= accept && ((dec.cls == CLS_LD) || (dec.cls == CLS_ST));
      mem_rw_ex_reg <= accept && (dec.cls == CLS_ST);
      if (!stall)
        imm_reg <= bus.ins[IMM_LSB +: IMM_W];
    end
  end

  assign bus.stall          = stall;
  assign bus.op_dec         = op_dec_reg;
  assign bus.mux_sel_a      = mux_sel_a_reg;
  assign bus.mux_sel_b      = mux_sel_b_reg;
  assign bus.imm_sel        = imm_sel_reg;
  assign bus.mem_en_ex      = mem_en_ex_reg;
  assign bus.mem_rw_ex      = mem_rw_ex_reg;
  assign bus.imm            = imm_reg;
  assign bus.rw_dm          = trk_reg[1].valid ? trk_reg[1].dest[REG_AW-1:0] : '0;
  assign bus.mem_mux_sel_dm = trk_reg[1].valid && trk_reg[1].is_load;

endmodule

// File: tb/tb_dependency_check_pipe.sv
// Bench for dependency_check_pipe: two instances (ZERO_REG = 1 and 0) share
// stimulus; a table of per-cycle vectors is applied through a scoreboard
// queue, followed by hand-written reset sequences.
module tb_dependency_check_pipe;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dependency_check_pipe_if #(.REG_AW(5), .SEL_W(2)) if_z ();
  dependency_check_pipe_if #(.REG_AW(5), .SEL_W(2)) if_n ();

  dependency_check_pipe #(.REG_AW(5), .FWD_DEPTH(3), .SEL_W(2), .ZERO_REG(1)) dut_z (
    .clk   (clk),
    .reset (reset),
    .bus   (if_z)
  );

  dependency_check_pipe #(.REG_AW(5), .FWD_DEPTH(3), .SEL_W(2), .ZERO_REG(0)) dut_n (
    .clk   (clk),
    .reset (reset),
    .bus   (if_n)
  );

  typedef struct {
    logic        v;
    logic [31:0] ins;
    logic        stall;
    logic [5:0]  op;
    logic [1:0]  sa;
    logic [1:0]  sb;
    logic [1:0]  sa_n;
    logic [1:0]  sb_n;
    logic        isel;
    logic        men;
    logic        mrw;
    logic [15:0] imm;
    logic [4:0]  rwdm;
    logic        mmdm;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(input logic [5:0] op, input int rd, input int rs, input int rt);
    return {op, 5'(rd), 5'(rs), 5'(rt), 11'b0};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input int rd, input int rs, input logic [15:0] im);
    return {op, 5'(rd), 5'(rs), im};
  endfunction

  task automatic add(input logic v, input logic [31:0] ins, input logic st, input logic [5:0] op,
                     input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] sa_n, input logic [1:0] sb_n,
                     input logic isel, input logic men, input logic mrw, input logic [15:0] imm,
                     input logic [4:0] rwdm, input logic mmdm);
    vec_t e;
    e.v = v; e.ins = ins; e.stall = st; e.op = op;
    e.sa = sa; e.sb = sb; e.sa_n = sa_n; e.sb_n = sb_n;
    e.isel = isel; e.men = men; e.mrw = mrw; e.imm = imm;
    e.rwdm = rwdm; e.mmdm = mmdm;
    tbl.push_back(e);
  endtask

  task automatic drive(input logic v, input logic [31:0] ins);
    if_z.ins_valid = v; if_z.ins = ins;
    if_n.ins_valid = v; if_n.ins = ins;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " stall"}, 32'(if_z.stall), 0);
    chk({tag, " op_dec"}, 32'(if_z.op_dec), 0);
    chk({tag, " sel_a"}, 32'(if_z.mux_sel_a), 0);
    chk({tag, " sel_b"}, 32'(if_z.mux_sel_b), 0);
    chk({tag, " imm_sel"}, 32'(if_z.imm_sel), 0);
    chk({tag, " mem_en"}, 32'(if_z.mem_en_ex), 0);
    chk({tag, " mem_rw"}, 32'(if_z.mem_rw_ex), 0);
    chk({tag, " imm"}, 32'(if_z.imm), 0);
    chk({tag, " rw_dm"}, 32'(if_z.rw_dm), 0);
    chk({tag, " mem_mux_dm"}, 32'(if_z.mem_mux_sel_dm), 0);
  endtask

  localparam logic [5:0] ADD = 6'h00, SUB = 6'h01, ADDI = 6'h08, LD = 6'h14, ST = 6'h15;

  initial begin
    vec_t e;
    drive(1'b1, 32'h0022_1800);

    //   v  ins                          st op    sa sb san sbn is me mr imm       rw  mm
    add(1, 32'h0022_1800,               0, ADD,  0, 0, 0, 0,  0, 0, 0, 16'h1800, 0,  0);
    add(1, r_ins(ADD, 3, 1, 2),         0, ADD,  1, 0, 1, 0,  0, 0, 0, 16'h1000, 1,  0);
    add(1, r_ins(SUB, 5, 3, 4),         0, SUB,  1, 0, 1, 0,  0, 0, 0, 16'h2000, 3,  0);
    add(1, r_ins(ADD, 8, 6, 7),         0, ADD,  0, 0, 0, 0,  0, 0, 0, 16'h3800, 5,  0);
    add(0, 32'h0,                       0, 6'h0, 0, 0, 0, 0,  0, 0, 0, 16'h0000, 8,  0);
    add(1, r_ins(SUB, 9, 8, 10),        0, SUB,  2, 0, 2, 0,  0, 0, 0, 16'h5000, 0,  0);
    add(1, r_ins(ADD, 11, 12, 13),      0, ADD,  0, 0, 0, 0,  0, 0, 0, 16'h6800, 9,  0);
    add(0, 32'h0,                       0, 6'h0, 0, 0, 0, 0,  0, 0, 0, 16'h0000, 11, 0);
    add(0, 32'h0,                       0, 6'h0, 0, 0, 0, 0,  0, 0, 0, 16'h0000, 0,  0);
    add(1, r_ins(SUB, 14, 11, 9),       0, SUB,  3, 0, 3, 0,  0, 0, 0, 16'h4800, 0,  0);
    add(1, i_ins(LD, 4, 1, 16'h0003),   0, LD,   0, 0, 0, 0,  1, 1, 0, 16'h0003, 14, 0);
    add(1, r_ins(ADD, 6, 4, 2),         1, 6'h0, 0, 0, 0, 0,  0, 0, 0, 16'h0003, 4,  1);
    add(1, r_ins(ADD, 6, 4, 2),         0, ADD,  2, 0, 2, 0,  0, 0, 0, 16'h1000, 0,  0);
    add(1, r_ins(ADD, 4, 5, 5),         0, ADD,  0, 0, 0, 0,  0, 0, 0, 16'h2800, 6,  0);
    add(1, i_ins(ST, 4, 1, 16'h0005),   0, ST,   0, 1, 0, 1,  1, 1, 1, 16'h0005, 4,  0);
    add(1, r_ins(ADD, 10, 4, 4),        0, ADD,  2, 2, 2, 2,  0, 0, 0, 16'h2000, 4,  0);
    add(1, r_ins(ADD, 0, 1, 2),         0, ADD,  0, 0, 0, 0,  0, 0, 0, 16'h1000, 10, 0);
    add(1, r_ins(ADD, 7, 0, 0),         0, ADD,  0, 0, 1, 1,  0, 0, 0, 16'h0000, 0,  0);
    add(1, i_ins(ADDI, 2, 7, 16'h3800), 0, ADDI, 1, 0, 1, 0,  1, 0, 0, 16'h3800, 7,  0);
    add(1, i_ins(LD, 9, 2, 16'h0001),   0, LD,   1, 0, 1, 0,  1, 1, 0, 16'h0001, 2,  0);

    // Reset held low: everything quiet
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    $display("reset held: stall=%0b op_dec=%h", if_z.stall, if_z.op_dec);
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[i]) begin
      string t;
      if (i != 0) @(negedge clk);
      drive(tbl[i].v, tbl[i].ins);
      exp_q.push_back(tbl[i]);
      #1;
      t = $sformatf("v%0d", i);
      chk({t, " stall"}, 32'(if_z.stall), 32'(tbl[i].stall));
      chk({t, " stall_n"}, 32'(if_n.stall), 32'(tbl[i].stall));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk({t, " op_dec"}, 32'(if_z.op_dec), 32'(e.op));
      chk({t, " sel_a"}, 32'(if_z.mux_sel_a), 32'(e.sa));
      chk({t, " sel_b"}, 32'(if_z.mux_sel_b), 32'(e.sb));
      chk({t, " sel_a_nz"}, 32'(if_n.mux_sel_a), 32'(e.sa_n));
      chk({t, " sel_b_nz"}, 32'(if_n.mux_sel_b), 32'(e.sb_n));
      chk({t, " imm_sel"}, 32'(if_z.imm_sel), 32'(e.isel));
      chk({t, " mem_en"}, 32'(if_z.mem_en_ex), 32'(e.men));
      chk({t, " mem_rw"}, 32'(if_z.mem_rw_ex), 32'(e.mrw));
      chk({t, " imm"}, 32'(if_z.imm), 32'(e.imm));
      chk({t, " rw_dm"}, 32'(if_z.rw_dm), 32'(e.rwdm));
      chk({t, " mem_mux_dm"}, 32'(if_z.mem_mux_sel_dm), 32'(e.mmdm));
      $display("vec %0d v=%0b ins=%h op=%h a=%0d b=%0d imm=%h rw_dm=%0d",
               i, e.v, e.ins, if_z.op_dec, if_z.mux_sel_a, if_z.mux_sel_b, if_z.imm, if_z.rw_dm);
    end

    // Reset asserted in the middle of a load-use stall (LD r9 now in EX)
    @(negedge clk);
    drive(1'b1, r_ins(ADD, 3, 9, 1));
    #1;
    chk("midrst pre stall", 32'(if_z.stall), 1);
    #1;
    reset = 1'b0;
    #1;
    check_all_zero("midrst");
    chk("midrst stall_n", 32'(if_n.stall), 0);
    $display("reset mid-stall: stall=%0b op_dec=%h", if_z.stall, if_z.op_dec);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("post-rst stall", 32'(if_z.stall), 0);
    @(posedge clk);
    #1;
    chk("post-rst sel_a", 32'(if_z.mux_sel_a), 0);
    chk("post-rst sel_a_nz", 32'(if_n.mux_sel_a), 0);
    chk("post-rst sel_b", 32'(if_z.mux_sel_b), 0);
    chk("post-rst op_dec", 32'(if_z.op_dec), 32'(ADD));
    chk("post-rst imm", 32'(if_z.imm), 32'h0800);
    $display("post reset issue: a=%0d imm=%h", if_z.mux_sel_a, if_z.imm);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
